// File: rtl/multi_bit_sync_edge.sv
// ============================================================================
// Module      : multi_bit_sync_edge
// Description : N-channel async-level synchroniser. Each channel has a flop
//               chain, an optional stability filter (SYNC_FILTER_EN) and
//               registered rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_bit_sync_edge #(
    parameter int WIDTH      = 4,
    parameter int STAGES     = 2,
    parameter int FILTER_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("multi_bit_sync_edge: STAGES must be >= 2");
        end
        if (FILTER_CYC < 1) begin : g_bad_filter
            $error("multi_bit_sync_edge: FILTER_CYC must be >= 1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("multi_bit_sync_edge: WIDTH must be >= 1");
        end
    endgenerate

`ifdef SYNC_FILTER_EN
    localparam int              CNT_W     = $clog2(FILTER_CYC + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(FILTER_CYC - 1);
`endif

    logic [WIDTH-1:0] w_lvl_next;
    logic [WIDTH-1:0] r_lvl;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_any_edge;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            logic [STAGES-1:0] r_sync;
            logic              w_s_last;
            logic              w_lvl_nxt;

            // Plain shift chain: only r_sync[0] may resolve from metastability.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], async_in[i]};
                end
            end

            assign w_s_last = r_sync[STAGES-1];

`ifdef SYNC_FILTER_EN
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;

            always_comb begin
                w_cnt_next = '0;
                w_lvl_nxt  = r_lvl[i];
                if (w_s_last != r_lvl[i]) begin
                    if (r_cnt == c_cnt_max) begin
                        w_lvl_nxt = w_s_last;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end
`else
            assign w_lvl_nxt = w_s_last;
`endif

            assign w_lvl_next[i] = w_lvl_nxt;
        end
    endgenerate

    // Pulses are derived from the same next-level so they line up with sync_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl      <= '0;
            r_rise     <= '0;
            r_fall     <= '0;
            r_any_edge <= 1'b0;
        end else begin
            r_lvl      <= w_lvl_next;
            r_rise     <= ~r_lvl & w_lvl_next;
            r_fall     <= r_lvl & ~w_lvl_next;
            r_any_edge <= |(r_lvl ^ w_lvl_next);
        end
    end

    assign sync_out = r_lvl;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign any_edge = r_any_edge;

endmodule

`default_nettype wire

// File: tb/tb_multi_bit_sync_edge.sv
// ============================================================================
// Module      : tb_multi_bit_sync_edge
// Description : Self-checking bench for multi_bit_sync_edge (table + sequences,
//               per-cycle scoreboard). Honours SYNC_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_bit_sync_edge;

    localparam int WIDTH      = 4;
    localparam int STAGES     = 2;
    localparam int FILTER_CYC = 4;
`ifdef SYNC_FILTER_EN
    localparam int FEFF = FILTER_CYC;
`else
    localparam int FEFF = 1;
`endif
    localparam int LAT = STAGES + FEFF;

    typedef struct {
        logic [3:0] din;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    typedef struct {
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_edge;

    int   checks;
    int   errors;
    exp_t sb[$];
    vec_t vecs[10];

    multi_bit_sync_edge #(
        .WIDTH      (WIDTH),
        .STAGES     (STAGES),
        .FILTER_CYC (FILTER_CYC)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (async_in),
        .sync_out (sync_out),
        .rise     (rise),
        .fall     (fall),
        .any_edge (any_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, got, exp);
        end
    endtask

    task automatic chk_all(input logic [3:0] lvl, input logic [3:0] r, input logic [3:0] f);
        chk("sync_out", sync_out, lvl);
        chk("rise", rise, r);
        chk("fall", fall, f);
        chk("any_edge", {3'b000, any_edge}, {3'b000, |(r | f)});
    endtask

    task automatic push_exp(input logic [3:0] lvl, input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.lvl  = lvl;
        e.rise = r;
        e.fall = f;
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus and compare against the oldest expectation.
    task automatic tick(input logic [3:0] din);
        exp_t e;
        @(negedge clk);
        async_in = din;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard at %0t: got empty queue required an entry", $time);
        end else begin
            e = sb.pop_front();
            chk_all(e.lvl, e.rise, e.fall);
        end
    endtask

    task automatic step(input logic [3:0] din, input logic [3:0] prev,
                        input logic [3:0] lvl, input logic [3:0] r, input logic [3:0] f);
        for (int c = 1; c <= LAT + 1; c++) begin
            if (c < LAT)       push_exp(prev, 4'h0, 4'h0);
            else if (c == LAT) push_exp(lvl, r, f);
            else               push_exp(lvl, 4'h0, 4'h0);
            tick(din);
        end
    endtask

    // Input pulse of 'len' cycles on 'mask' starting from an all-zero state.
    task automatic pulse_seq(input logic [3:0] mask, input int len);
        bit accepted;
        accepted = (len >= FEFF);
        for (int c = 1; c <= LAT + len + 2; c++) begin
            push_exp((accepted && c >= LAT && c < LAT + len) ? mask : 4'h0,
                     (accepted && c == LAT) ? mask : 4'h0,
                     (accepted && c == LAT + len) ? mask : 4'h0);
            tick((c <= len) ? mask : 4'h0);
        end
    endtask

    initial begin
        logic [3:0] prev;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        async_in = 4'hF;

        vecs[0] = '{din: 4'h0, lvl: 4'h0, rise: 4'h0, fall: 4'hF};
        vecs[1] = '{din: 4'h1, lvl: 4'h1, rise: 4'h1, fall: 4'h0};
        vecs[2] = '{din: 4'h0, lvl: 4'h0, rise: 4'h0, fall: 4'h1};
        vecs[3] = '{din: 4'h8, lvl: 4'h8, rise: 4'h8, fall: 4'h0};
        vecs[4] = '{din: 4'h4, lvl: 4'h4, rise: 4'h4, fall: 4'h8};
        vecs[5] = '{din: 4'hF, lvl: 4'hF, rise: 4'hB, fall: 4'h0};
        vecs[6] = '{din: 4'h0, lvl: 4'h0, rise: 4'h0, fall: 4'hF};
        vecs[7] = '{din: 4'hA, lvl: 4'hA, rise: 4'hA, fall: 4'h0};
        vecs[8] = '{din: 4'h5, lvl: 4'h5, rise: 4'h5, fall: 4'hA};
        vecs[9] = '{din: 4'h0, lvl: 4'h0, rise: 4'h0, fall: 4'h5};

        // Held in reset with all inputs high: outputs stay clear.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk_all(4'h0, 4'h0, 4'h0);
        end
        #1 rst_n = 1'b1;
        step(4'hF, 4'h0, 4'hF, 4'hF, 4'h0);

        prev = 4'hF;
        for (int v = 0; v < 10; v++) begin
            step(vecs[v].din, prev, vecs[v].lvl, vecs[v].rise, vecs[v].fall);
            prev = vecs[v].lvl;
        end

        pulse_seq(4'h2, 2);
        pulse_seq(4'h4, FILTER_CYC - 1);
        pulse_seq(4'h4, FILTER_CYC);

        // Reset in the middle of a pending change on channel 3.
        step(4'h1, 4'h0, 4'h1, 4'h1, 4'h0);
        for (int c = 1; c <= LAT - 2; c++) begin
            push_exp(4'h1, 4'h0, 4'h0);
            tick(4'h9);
        end
        #2 rst_n = 1'b0;
        #1 chk_all(4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk_all(4'h0, 4'h0, 4'h0);
        end
        #1 rst_n = 1'b1;
        step(4'h9, 4'h0, 4'h9, 4'h9, 4'h0);
        step(4'h0, 4'h9, 4'h0, 4'h0, 4'h9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
